// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit with architectural HI/LO registers.
//   One multiplier bit (shift-add) or one quotient bit (restoring division)
//   is processed per RUN cycle, so an operation takes W RUN cycles plus one
//   FIX cycle in which signs are applied and HI/LO are written.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-low reset
//   start    in   begin an operation (accepted only in IDLE)
//   op       in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   Rs_data  in   W  multiplicand / dividend; also the mthi/mtlo source
//   Rt_data  in   W  multiplier / divisor
//   mthi     in   write Rs_data into HI (IDLE with start=0 only)
//   mtlo     in   write Rs_data into LO (IDLE with start=0 only)
//   busy     out  operation in progress (RUN or FIX)
//   done     out  one-cycle pulse; HI/LO hold the new result while high
//   hi       out  W  product upper half, or remainder
//   lo       out  W  product lower half, or quotient
module mult_div_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] Rs_data,
  input  logic [W-1:0] Rt_data,
  input  logic         mthi,
  input  logic         mtlo,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;          // negate product / quotient
  logic           rem_neg_q, rem_neg_d;  // negate remainder (dividend was negative)
  logic           div_zero_q, div_zero_d;
  logic [W-1:0]   opnd_q, opnd_d;        // multiplicand (mul) or divisor (div)
  logic [W-1:0]   acc_hi_q, acc_hi_d;    // product upper half / partial remainder
  logic [W-1:0]   acc_lo_q, acc_lo_d;    // multiplier bits / dividend -> quotient
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           rs_neg_s, rt_neg_s;
  logic [W-1:0]   rs_mag_s, rt_mag_s;
  logic [W:0]     mul_sum_s;
  logic [W:0]     div_trial_s;
  logic [W:0]     div_diff_s;
  logic [2*W-1:0] prod_neg_s;

  // Operand magnitudes and the per-iteration datapath arithmetic.
  always_comb begin
    rs_neg_s    = op[0] & Rs_data[W-1];
    rt_neg_s    = op[0] & Rt_data[W-1];
    rs_mag_s    = rs_neg_s ? (~Rs_data + W'(1)) : Rs_data;
    rt_mag_s    = rt_neg_s ? (~Rt_data + W'(1)) : Rt_data;
    // Shift-add: add multiplicand when the current multiplier bit is set;
    // the carry becomes the new top bit after the right shift.
    mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    // Restoring division: shift next dividend bit into the remainder and
    // try subtracting the divisor; a borrow in bit W means "restore".
    div_trial_s = {acc_hi_q, acc_lo_q[W-1]};
    div_diff_s  = div_trial_s - {1'b0, opnd_q};
    prod_neg_s  = ~{acc_hi_q, acc_lo_q} + {{(2*W-1){1'b0}}, 1'b1};
  end

  // Next-state logic for the IDLE/RUN/FIX sequencer and all registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          busy_d     = 1'b1;
          cnt_d      = CW'(W - 1);
          is_div_d   = op[1];
          neg_d      = rs_neg_s ^ rt_neg_s;
          rem_neg_d  = rs_neg_s;
          div_zero_d = op[1] & (Rt_data == {W{1'b0}});
          acc_hi_d   = {W{1'b0}};
          if (op[1]) begin
            opnd_d   = rt_mag_s;
            acc_lo_d = rs_mag_s;
          end else begin
            opnd_d   = rs_mag_s;
            acc_lo_d = rt_mag_s;
          end
        end else begin
          busy_d = 1'b0;
          if (mthi) begin
            hi_d = Rs_data;
          end else begin
            hi_d = hi_q;
          end
          if (mtlo) begin
            lo_d = Rs_data;
          end else begin
            lo_d = lo_q;
          end
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          if (!div_diff_s[W]) begin
            acc_hi_d = div_diff_s[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
          end else begin
            acc_hi_d = div_trial_s[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
          end
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum_s, acc_lo_q[W-1:1]};
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Divide by zero leaves the remainder equal to the dividend, which
          // after the remainder sign fix is Rs_data unchanged.
          if (div_zero_q) begin
            lo_d = {W{1'b1}};
          end else if (neg_q) begin
            lo_d = ~acc_lo_q + W'(1);
          end else begin
            lo_d = acc_lo_q;
          end
          if (rem_neg_q) begin
            hi_d = ~acc_hi_q + W'(1);
          end else begin
            hi_d = acc_hi_q;
          end
        end else begin
          if (neg_q) begin
            {hi_d, lo_d} = prod_neg_s;
          end else begin
            {hi_d, lo_d} = {acc_hi_q, acc_lo_q};
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= {W{1'b0}};
      acc_hi_q   <= {W{1'b0}};
      acc_lo_q   <= {W{1'b0}};
      hi_q       <= {W{1'b0}};
      lo_q       <= {W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Rs_data;
  logic [31:0] Rt_data;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // Architectural HI/LO as the bench expects them.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .Rs_data(Rs_data), .Rt_data(Rt_data), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation's meaning; returns {hi, lo}.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: return ua * ub;
      2'd1: return 64'(sa * sb);
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Called just after a clock edge. Issues an operation (with mthi/mtlo also
  // raised, which must lose to start), scrambles inputs during the run, and
  // returns in the done cycle so a following call exercises back-to-back.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    bit seen, busy_ok, hold_ok;
    start = 1'b1; op = o; Rs_data = a; Rt_data = b; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_on_accept"}, busy, 64'd1);
    check({tag, "_hold_on_accept"}, {hi, lo}, {m_hi, m_lo});
    cyc = 0; seen = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!seen && cyc < 60) begin
      Rs_data = $urandom; Rt_data = $urandom; op = 2'($urandom);
      start = (cyc == 3);
      mthi  = (cyc == 5);
      mtlo  = (cyc == 5);
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      end
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check({tag, "_done_seen"}, seen, 64'd1);
    check({tag, "_latency"}, cyc, 64'd33);
    check({tag, "_busy_run"}, busy_ok, 64'd1);
    check({tag, "_hold_run"}, hold_ok, 64'd1);
    check({tag, "_busy_at_done"}, busy, 64'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  task automatic idle_step(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 64'd0);
    check({tag, "_busy_low"}, busy, 64'd0);
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [63:0] r;
    logic [1:0]  o;
    logic [31:0] a, b;
    int dcount;

    rst = 1'b0; start = 1'b0; op = 2'd0; Rs_data = 32'd0; Rt_data = 32'd0;
    mthi = 1'b0; mtlo = 1'b0;
    #12;
    check("reset_busy", busy, 64'd0);
    check("reset_done", done, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_step("post_reset");

    // Directed vectors, issued back-to-back.
    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg3x7", 2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min_sq", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg7_2", 2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_2", 2'd2, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_by0", 2'd2, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_by0", 2'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    idle_step("pulse_width");

    // Moves to HI/LO in IDLE.
    mtlo = 1'b1; Rs_data = 32'h0000_1234;
    @(posedge clk); #1;
    mtlo = 1'b0;
    m_lo = 32'h0000_1234;
    check("mtlo_lo", lo, 64'h1234);
    check("mtlo_hi_kept", hi, m_hi);
    a = $urandom;
    mthi = 1'b1; mtlo = 1'b1; Rs_data = a;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    m_hi = a; m_lo = a;
    check("mthilo_both", {hi, lo}, {a, a});

    // Randomized operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom);
      a = pick();
      b = pick();
      r = ref_op(o, a, b);
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, r[63:32], r[31:0]);
      if ($urandom_range(0, 1) == 1) idle_step($sformatf("rand%0d_idle", i));
    end
    idle_step("rand_end");

    // Reset in the middle of MULTU 5x6 with an ignored second start.
    start = 1'b1; op = 2'd0; Rs_data = 32'd5; Rt_data = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      start = (c == 4);
      Rs_data = (c == 4) ? 32'd9 : 32'd5;
      Rt_data = (c == 4) ? 32'd9 : 32'd6;
      @(posedge clk); #1;
    end
    start = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 64'd0);
    check("abort_done", done, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check("abort_no_activity", dcount, 64'd0);
    run_op("multu_after_rst", 2'd0, 32'd5, 32'd6, 32'd0, 32'd30);
    idle_step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
